cpu_controller: RTL and testbench
=================================

# cpu_controller

Moore state machine that sequences the simple-RISC datapath: instruction fetch from memory, PC update, decode, register read into A/B, ALU/shift, writeback, and LDR/STR memory access. It sits between the instruction decoder (which supplies `opcode`/`op` and consumes one-hot `nsel`) and the datapath, register file, PC and memory-address registers. It asserts one load/write strobe per step, so each instruction takes a fixed, documented number of cycles.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opcode  in  3  from decoder (IR[15:13])
- op  in  2  from decoder (IR[12:11])
- nsel  out  3  one-hot register select: 001 Rn, 010 Rd, 100 Rm
- loada, loadb, loadc, loads  out  1 each  datapath register/status enables
- asel  out  1  1: ALU A input = 0
- bsel  out  1  1: ALU B input = sximm5
- vsel  out  2  writeback source: 00 C, 01 sximm8, 11 mdata
- write  out  1  register-file write enable
- load_ir, load_pc, reset_pc, load_addr  out  1 each  IR/PC/data-address strobes
- addr_sel  out  1  1: memory address = PC; 0: data-address register
- mem_cmd  out  2  00 none, 01 read, 10 write
- halted  out  1  high in HALT state

## Operation
- Outputs depend only on state. Defaults in every state: strobes 0, nsel=001, vsel=00, asel=bsel=0, addr_sel=1, mem_cmd=00.
- RST: reset_pc=1, load_pc=1 -> IF1.
- IF1: mem_cmd=01, addr_sel=1 -> IF2. IF2: the same outputs plus load_ir=1 -> UPC. UPC: load_pc=1 -> DEC.
- DEC: no outputs. Transition by {opcode,op}:
  - 110_10 MOV imm -> WIMM
  - 110_00 MOV reg -> GETB
  - 101_00 ADD, 101_01 CMP, 101_10 AND -> GETA
  - 101_11 MVN -> GETB
  - 011_00 LDR, 100_00 STR -> GETA
  - 111_xx -> HALT
  - Any other encoding is a NOP -> IF1.
- WIMM: nsel=001, vsel=01, write=1 -> IF1.
- GETA: nsel=001, loada=1. LDR/STR -> ADDR; otherwise -> GETB.
- GETB: nsel=100, loadb=1. CMP -> CMPS; otherwise -> EXE.
- EXE: loadc=1; asel=1 for MOV reg and MVN, else 0; bsel=0 -> WRD.
- CMPS: loads=1, asel=bsel=0 -> IF1.
- WRD: nsel=010, vsel=00, write=1 -> IF1.
- ADDR: asel=0, bsel=1, loadc=1 -> LADDR. LADDR: load_addr=1. LDR -> RD1; STR -> GETD.
- RD1: addr_sel=0, mem_cmd=01 -> RD2. RD2: addr_sel=0, mem_cmd=01, nsel=010, vsel=11, write=1 -> IF1.
- GETD: nsel=010, loadb=1 -> PASS. PASS: asel=1, bsel=0, loadc=1 -> WR. WR: addr_sel=0, mem_cmd=10 -> IF1.
- HALT: halted=1, all strobes 0. Stays in HALT until reset.
- Never assert write and loadc in the same cycle. Never assert more than one nsel bit.

## Timing
- Reset: when reset=1 at a rising edge, the next state is RST. While reset=1, outputs are forced combinationally to RST values (write=0, mem_cmd=00, load_ir=0), so a reset raised mid-instruction never commits a register or memory write.
- Memory is synchronous with one cycle of read latency. Read data is valid in the cycle after a read command is issued.
- Cycle counts, DEC to IF1 inclusive of fetch (IF1..DEC = 4 cycles):
  - MOV imm: 5
  - MOV reg, MVN: 7
  - ADD, AND: 8
  - CMP: 7
  - LDR: 9
  - STR: 10
  - NOP: 4
- The state register updates only on clk. opcode/op are sampled in DEC only. IR is stable from UPC until the next IF2.

## Test plan
- Reset mid-ADD (in WRD): write=0 that cycle. Next cycle is RST with reset_pc=load_pc=1, then IF1 with mem_cmd=01, addr_sel=1.
- MOV R3,#-5 (IR=16'hD3FB): WIMM after 4 cycles with nsel=001, vsel=01, write=1. Next state IF1 (5 cycles total).
- ADD R2,R1,R0 (IR=16'hA140): observe nsel 001 (loada), 100 (loadb), then EXE with asel=0, loadc=1, then WRD with nsel=010, write=1. Exactly 8 cycles; loads stays 0 throughout.
- CMP R1,R0 (IR=16'hA900): loads=1 for exactly one cycle, write never asserted, 7 cycles.
- LDR R4,[R1,#3] then STR R4,[R1,#3]:
  - LDR: bsel=1 in ADDR; RD2 shows vsel=11, nsel=010, write=1.
  - STR: GETD shows nsel=010; WR shows mem_cmd=10, addr_sel=0; 9 and 10 cycles respectively.
- HALT (IR=16'hE000) then illegal opcode 000: halted=1 held for 20 cycles with no strobes. After reset, an opcode-000 instruction returns to IF1 4 cycles after entering IF1, with no write.

Source files
------------

// File: rtl/cpu_controller.sv
// cpu_controller: Moore sequencer for the simple-RISC datapath.
// Walks fetch, PC update, decode, operand read, execute, writeback and
// LDR/STR memory access, asserting one strobe per step.
module cpu_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       load_addr,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic       halted
);

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WIMM, S_GETA, S_GETB, S_EXE,
    S_CMPS, S_WRD, S_ADDR, S_LADDR, S_RD1, S_RD2, S_GETD, S_PASS, S_WR,
    S_HALT
  } state_t;

  localparam logic [4:0] I_LDR     = 5'b011_00;
  localparam logic [4:0] I_CMP     = 5'b101_01;
  localparam logic [4:0] I_MVN     = 5'b101_11;
  localparam logic [4:0] I_MOV_REG = 5'b110_00;

  state_t     state_q, state_d;
  logic [4:0] ins_q, ins_d;

  // State register and the instruction class captured while in DEC
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      ins_q   <= ins_d;
    end
  end

  // Next-state logic; opcode/op are only looked at in DEC
  always_comb begin
    state_d = state_q;
    ins_d   = ins_q;
    case (state_q)
      S_RST:  state_d = S_IF1;
      S_IF1:  state_d = S_IF2;
      S_IF2:  state_d = S_UPC;
      S_UPC:  state_d = S_DEC;
      S_DEC: begin
        ins_d = {opcode, op};
        casez ({opcode, op})
          5'b110_10:                   state_d = S_WIMM;
          5'b110_00, 5'b101_11:        state_d = S_GETB;
          5'b101_00, 5'b101_01,
          5'b101_10, 5'b011_00,
          5'b100_00:                   state_d = S_GETA;
          5'b111_??:                   state_d = S_HALT;
          default:                     state_d = S_IF1;
        endcase
      end
      S_WIMM:  state_d = S_IF1;
      S_GETA:  state_d = (ins_q == I_LDR || ins_q == 5'b100_00) ? S_ADDR : S_GETB;
      S_GETB:  state_d = (ins_q == I_CMP) ? S_CMPS : S_EXE;
      S_EXE:   state_d = S_WRD;
      S_CMPS:  state_d = S_IF1;
      S_WRD:   state_d = S_IF1;
      S_ADDR:  state_d = S_LADDR;
      S_LADDR: state_d = (ins_q == I_LDR) ? S_RD1 : S_GETD;
      S_RD1:   state_d = S_RD2;
      S_RD2:   state_d = S_IF1;
      S_GETD:  state_d = S_PASS;
      S_PASS:  state_d = S_WR;
      S_WR:    state_d = S_IF1;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Moore outputs; reset forces RST values so no write lands mid-instruction
  always_comb begin
    nsel      = 3'b001;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    vsel      = 2'b00;
    write     = 1'b0;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    load_addr = 1'b0;
    addr_sel  = 1'b1;
    mem_cmd   = 2'b00;
    halted    = 1'b0;
    if (reset) begin
      reset_pc = 1'b1;
      load_pc  = 1'b1;
    end else begin
      case (state_q)
        S_RST:   begin reset_pc = 1'b1; load_pc = 1'b1; end
        S_IF1:   mem_cmd = 2'b01;
        S_IF2:   begin mem_cmd = 2'b01; load_ir = 1'b1; end
        S_UPC:   load_pc = 1'b1;
        S_WIMM:  begin vsel = 2'b01; write = 1'b1; end
        S_GETA:  loada = 1'b1;
        S_GETB:  begin nsel = 3'b100; loadb = 1'b1; end
        S_EXE:   begin
          loadc = 1'b1;
          asel  = (ins_q == I_MOV_REG) || (ins_q == I_MVN);
        end
        S_CMPS:  loads = 1'b1;
        S_WRD:   begin nsel = 3'b010; write = 1'b1; end
        S_ADDR:  begin bsel = 1'b1; loadc = 1'b1; end
        S_LADDR: load_addr = 1'b1;
        S_RD1:   begin addr_sel = 1'b0; mem_cmd = 2'b01; end
        S_RD2:   begin
          addr_sel = 1'b0;
          mem_cmd  = 2'b01;
          nsel     = 3'b010;
          vsel     = 2'b11;
          write    = 1'b1;
        end
        S_GETD:  begin nsel = 3'b010; loadb = 1'b1; end
        S_PASS:  begin asel = 1'b1; loadc = 1'b1; end
        S_WR:    begin addr_sel = 1'b0; mem_cmd = 2'b10; end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed cycle-by-cycle check of the controller's
// output vector against hand-written per-step expectations.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] nsel;
  logic       loada, loadb, loadc, loads, asel, bsel;
  logic [1:0] vsel;
  logic       write, load_ir, load_pc, reset_pc, load_addr, addr_sel;
  logic [1:0] mem_cmd;
  logic       halted;

  int unsigned nvec  = 0;
  int unsigned nfail = 0;

  typedef struct packed {
    logic       halted;
    logic [1:0] mem_cmd;
    logic       addr_sel;
    logic       load_addr;
    logic       reset_pc;
    logic       load_pc;
    logic       load_ir;
    logic       write;
    logic [1:0] vsel;
    logic       bsel;
    logic       asel;
    logic       loads;
    logic       loadc;
    logic       loadb;
    logic       loada;
    logic [2:0] nsel;
  } outs_t;

  logic [19:0] obs_w;
  assign obs_w = {halted, mem_cmd, addr_sel, load_addr, reset_pc, load_pc,
                  load_ir, write, vsel, bsel, asel, loads, loadc, loadb,
                  loada, nsel};

  cpu_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .nsel(nsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .write(write),
    .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
    .load_addr(load_addr), .addr_sel(addr_sel), .mem_cmd(mem_cmd),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Expected outputs per step, written out from the state table
  function automatic outs_t x(input string st);
    outs_t e;
    e          = '0;
    e.nsel     = 3'b001;
    e.addr_sel = 1'b1;
    case (st)
      "RST":   begin e.reset_pc = 1'b1; e.load_pc = 1'b1; end
      "IF1":   e.mem_cmd = 2'b01;
      "IF2":   begin e.mem_cmd = 2'b01; e.load_ir = 1'b1; end
      "UPC":   e.load_pc = 1'b1;
      "DEC":   ;
      "WIMM":  begin e.vsel = 2'b01; e.write = 1'b1; end
      "GETA":  e.loada = 1'b1;
      "GETB":  begin e.nsel = 3'b100; e.loadb = 1'b1; end
      "EXE0":  e.loadc = 1'b1;
      "EXE1":  begin e.loadc = 1'b1; e.asel = 1'b1; end
      "CMPS":  e.loads = 1'b1;
      "WRD":   begin e.nsel = 3'b010; e.write = 1'b1; end
      "ADDR":  begin e.bsel = 1'b1; e.loadc = 1'b1; end
      "LADDR": e.load_addr = 1'b1;
      "RD1":   begin e.addr_sel = 1'b0; e.mem_cmd = 2'b01; end
      "RD2":   begin
        e.addr_sel = 1'b0; e.mem_cmd = 2'b01; e.nsel = 3'b010;
        e.vsel = 2'b11; e.write = 1'b1;
      end
      "GETD":  begin e.nsel = 3'b010; e.loadb = 1'b1; end
      "PASS":  begin e.asel = 1'b1; e.loadc = 1'b1; end
      "WR":    begin e.addr_sel = 1'b0; e.mem_cmd = 2'b10; end
      "HALT":  e.halted = 1'b1;
      default: e = '1;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag);
    outs_t e;
    e = x(tag);
    nvec++;
    assert (obs_w === e) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_w, e);
    end
  endtask

  // Check the current cycle, then advance to just after the next edge
  task automatic step(input string tag);
    chk(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [2:0] opc, input logic [1:0] o);
    opcode = opc;
    op     = o;
    step("IF1"); step("IF2"); step("UPC"); step("DEC");
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 3'b000;
    op     = 2'b00;
    #1;
    chk("RST");                 // forced while reset is high
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    step("RST");

    // MOV R3,#-5 : 5 cycles
    fetch(3'b110, 2'b10); step("WIMM");
    // ADD : 8 cycles
    fetch(3'b101, 2'b00); step("GETA"); step("GETB"); step("EXE0"); step("WRD");
    // CMP : 7 cycles
    fetch(3'b101, 2'b01); step("GETA"); step("GETB"); step("CMPS");
    // MOV reg : 7 cycles
    fetch(3'b110, 2'b00); step("GETB"); step("EXE1"); step("WRD");
    // MVN : 7 cycles
    fetch(3'b101, 2'b11); step("GETB"); step("EXE1"); step("WRD");
    // AND : 8 cycles
    fetch(3'b101, 2'b10); step("GETA"); step("GETB"); step("EXE0"); step("WRD");
    // LDR : 9 cycles
    fetch(3'b011, 2'b00); step("GETA"); step("ADDR"); step("LADDR");
    step("RD1"); step("RD2");
    // STR : 10 cycles; decoder inputs change after DEC and must be ignored
    fetch(3'b100, 2'b00);
    opcode = 3'b101; op = 2'b01;
    step("GETA"); step("ADDR"); step("LADDR"); step("GETD"); step("PASS"); step("WR");
    // NOP : 4 cycles
    fetch(3'b000, 2'b00);
    // ADD interrupted by reset in WRD
    fetch(3'b101, 2'b00); step("GETA"); step("GETB"); step("EXE0");
    chk("WRD");
    reset = 1'b1;
    #1;
    chk("RST");                 // write suppressed while reset is high
    @(posedge clk); #1;
    reset = 1'b0;
    step("RST");
    // HALT, then an illegal opcode on the decoder: stays halted
    fetch(3'b111, 2'b00);
    opcode = 3'b000;
    for (int unsigned i = 0; i < 20; i++) step("HALT");
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    step("RST");
    // opcode 000 after reset: back to IF1 after 4 cycles, no write
    fetch(3'b000, 2'b00);
    step("IF1");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
